// File: rtl/mips_bus_access_seq.sv
// mips_bus_access_seq
//   Load/store sequencer between a multicycle MIPS core and an Avalon-style
//   memory bus. It takes one core request at a time. On stores it steers byte
//   lanes, and on loads it extracts and extends the addressed bytes. It rejects
//   misaligned and illegal-size requests without touching the bus. A watchdog
//   aborts transfers that stay stalled by waitrequest for too long.
//
// Parameters
//   ADDR_W   byte-address width
//   DATA_W   bus data width (32 or 64)
//   TIMEOUT  stalled bus cycles before abort; 0 disables the watchdog
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req_*               core request (valid/ready handshake, fields latched
//                       when the request is accepted)
//   resp_valid          one-cycle strobe; resp_rdata/resp_err hold afterwards
//   address, read, write, writedata, byteenable
//                       registered bus master outputs
//   waitrequest, readdata
//                       bus slave inputs, only looked at while in BUS
module mips_bus_access_seq #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int unsigned BL    = DATA_W / 8;
  localparam int unsigned LW    = $clog2(BL);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);
  // Abort happens on the TIMEOUT-th stalled cycle, i.e. when the count of
  // earlier stalled cycles equals TIMEOUT-1.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t            state, state_nx;
  logic [1:0]        size_r;
  logic              signed_r;
  logic [LW-1:0]     lane_r;
  logic [CNT_W-1:0]  wdog_cnt;

  logic              misaligned, size_illegal, req_err;
  logic              bus_done, timeout_hit;
  logic [15:0]       be_wide;
  logic [BL-1:0]     be_nx;
  logic [DATA_W-1:0] wd_nx;
  logic [DATA_W-1:0] rd_shift, keep, ld_data;
  logic              ld_msb;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

  // Request checks and store-side lane steering
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      2'd3:    misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
    size_illegal = (req_size == 2'd3) && (DATA_W < 64);
    req_err      = misaligned || size_illegal;

    be_wide = ((16'd1 << (5'd1 << req_size)) - 16'd1) << req_addr[LW-1:0];
    be_nx   = be_wide[BL-1:0];

    case (req_size)
      2'd0:    wd_nx = {BL{req_wdata[7:0]}};
      2'd1:    wd_nx = {(DATA_W/16){req_wdata[15:0]}};
      2'd2:    wd_nx = {(DATA_W/32){req_wdata[31:0]}};
      default: wd_nx = req_wdata;
    endcase
  end

  // Load-side extraction: shift the addressed lane down, mask, then extend
  always_comb begin
    rd_shift = readdata >> {lane_r, 3'b000};
    keep     = '1;
    ld_msb   = 1'b0;
    case (size_r)
      2'd0: begin keep = DATA_W'(8'hFF);         ld_msb = rd_shift[7];  end
      2'd1: begin keep = DATA_W'(16'hFFFF);      ld_msb = rd_shift[15]; end
      2'd2: begin keep = DATA_W'(32'hFFFF_FFFF); ld_msb = rd_shift[31]; end
      default: begin keep = '1;                  ld_msb = 1'b0;         end
    endcase
    ld_data = (rd_shift & keep) | ((signed_r && ld_msb) ? ~keep : '0);
  end

  assign bus_done    = (state == S_BUS) && !waitrequest;
  assign timeout_hit = (TIMEOUT != 0) && (state == S_BUS) && waitrequest &&
                       (wdog_cnt == TO_LAST);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (req_valid) state_nx = req_err ? S_RESP : S_BUS;
      S_BUS:   if (bus_done || timeout_hit) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      size_r     <= '0;
      signed_r   <= 1'b0;
      lane_r     <= '0;
      wdog_cnt   <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            size_r   <= req_size;
            signed_r <= req_signed;
            lane_r   <= req_addr[LW-1:0];
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              address    <= req_addr & ~ADDR_W'(BL - 1);
              read       <= !req_write;
              write      <= req_write;
              byteenable <= be_nx;
              writedata  <= wd_nx;
              wdog_cnt   <= '0;
            end
          end
        end
        S_BUS: begin
          if (bus_done) begin
            read       <= 1'b0;
            write      <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= write ? '0 : ld_data;
          end else if (timeout_hit) begin
            read       <= 1'b0;
            write      <= 1'b0;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_access_seq.sv
module tb_mips_bus_access_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_bus_access_seq #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  // Scramble the request fields after acceptance to prove they were latched
  task automatic drop_req();
    req_valid  = 1'b0;
    req_write  = ~req_write;
    req_size   = ~req_size;
    req_signed = ~req_signed;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5A5A_5A5A;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    waitrequest = 1'b0; readdata = '0;
    step(); step();
    chk("rst_ready", req_ready, 1);
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_address", address, 0);
    chk("rst_be", byteenable, 0);
    chk("rst_wdata", writedata, 0);
    chk("rst_rdata", resp_rdata, 0);
    reset = 1'b0;
    step();

    // 1: signed byte load from lane 3
    readdata = 32'h8011_2233;
    issue(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0);
    step();
    drop_req();
    chk("t1_read", read, 1);
    chk("t1_write", write, 0);
    chk("t1_address", address, 32'h1000);
    chk("t1_be", byteenable, 4'b1000);
    chk("t1_ready", req_ready, 0);
    chk("t1_resp_early", resp_valid, 0);
    step();
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_rdata", resp_rdata, 32'hFFFF_FF80);
    chk("t1_err", resp_err, 0);
    chk("t1_read_drop", read, 0);
    step();
    chk("t1_resp_once", resp_valid, 0);
    chk("t1_ready_back", req_ready, 1);
    chk("t1_rdata_hold", resp_rdata, 32'hFFFF_FF80);

    // 4: misaligned half load
    issue(1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'h0);
    step();
    drop_req();
    chk("t4_resp_valid", resp_valid, 1);
    chk("t4_err", resp_err, 1);
    chk("t4_read", read, 0);
    chk("t4_rdata", resp_rdata, 0);
    step();
    chk("t4_resp_once", resp_valid, 0);
    chk("t4_ready", req_ready, 1);
    chk("t4_err_hold", resp_err, 1);
    chk("t4_read_never", read, 0);

    // 4b: dword store on a 32-bit bus is illegal even when aligned
    issue(1'b1, 2'd3, 1'b0, 32'h0000_4000, 32'h1111_2222);
    step();
    drop_req();
    chk("t4b_resp_valid", resp_valid, 1);
    chk("t4b_err", resp_err, 1);
    chk("t4b_write", write, 0);
    step();

    // 2: half store to upper half-word
    readdata = 32'hAAAA_AAAA;
    issue(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_1234);
    step();
    drop_req();
    chk("t2_write", write, 1);
    chk("t2_read", read, 0);
    chk("t2_wdata", writedata, 32'h1234_1234);
    chk("t2_be", byteenable, 4'b1100);
    chk("t2_address", address, 32'h2000);
    step();
    chk("t2_resp_valid", resp_valid, 1);
    chk("t2_err", resp_err, 0);
    chk("t2_rdata", resp_rdata, 0);
    chk("t2_write_drop", write, 0);
    step();

    // 3: word load with three stalled cycles; a second request while busy is ignored
    waitrequest = 1'b1;
    readdata = 32'h1111_1111;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0);
    step();
    drop_req();
    chk("t3_read_c1", read, 1);
    chk("t3_be", byteenable, 4'b1111);
    step();
    chk("t3_read_c2", read, 1);
    issue(1'b1, 2'd2, 1'b0, 32'h0000_7000, 32'h9999_9999);
    step();
    chk("t3_read_c3", read, 1);
    chk("t3_addr_stable", address, 32'h3000);
    chk("t3_no_write", write, 0);
    req_valid = 1'b0;
    step();
    chk("t3_read_c4", read, 1);
    chk("t3_resp_early", resp_valid, 0);
    waitrequest = 1'b0;
    readdata = 32'hDEAD_BEEF;
    step();
    chk("t3_resp_valid", resp_valid, 1);
    chk("t3_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("t3_err", resp_err, 0);
    chk("t3_read_drop", read, 0);
    step();
    chk("t3_ready_back", req_ready, 1);

    // 5: waitrequest stuck high, watchdog of 8 cycles
    waitrequest = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0);
    step();
    drop_req();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t5_read_c%0d", k), read, 1);
      chk($sformatf("t5_no_resp_c%0d", k), resp_valid, 0);
      step();
    end
    chk("t5_read_drop", read, 0);
    chk("t5_resp_valid", resp_valid, 1);
    chk("t5_err", resp_err, 1);
    chk("t5_rdata", resp_rdata, 0);
    step();
    chk("t5_ready_back", req_ready, 1);
    chk("t5_resp_once", resp_valid, 0);

    // 6: reset pulsed in the middle of a stalled store
    issue(1'b1, 2'd2, 1'b0, 32'h0000_6000, 32'hCAFE_F00D);
    step();
    drop_req();
    chk("t6_write", write, 1);
    chk("t6_wdata", writedata, 32'hCAFE_F00D);
    #1 reset = 1'b1;
    #1;
    chk("t6_write_async", write, 0);
    chk("t6_addr_async", address, 0);
    chk("t6_ready_async", req_ready, 1);
    step();
    reset = 1'b0;
    waitrequest = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t6_no_resp_%0d", k), resp_valid, 0);
      chk($sformatf("t6_ready_%0d", k), req_ready, 1);
      chk($sformatf("t6_write_off_%0d", k), write, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
